main_memory: RTL
================

# main_memory

Multi-cycle backing data memory that sits directly downstream of the data-cache controller. It services the controller's `Memory_Read_En` (4-word block refill) and `Memory_Write_En` (single-word write-through) requests after a fixed latency. Each completion is signalled with a one-cycle `Mem_Done` pulse, which the controller uses to leave its Read/Write states. Storage is 1024 words of 32 bits, covering the 10-bit word address space (tag, line and block fields) that the cache uses.

## Interface

- `LATENCY`, default 4: cycles spent in a busy state before completion; legal range 1..15.
- `DEPTH_WORDS`, default 1024: number of words in the array; fixed by the 10-bit word address.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `Memory_Read_En`  input  1  block-read request from the cache controller.
- `Memory_Write_En`  input  1  word-write request from the cache controller.
- `Address`  input  32  byte address; word index = `Address[11:2]`, block base = `Address[11:4]`; bits [31:12] and [1:0] ignored.
- `Write_Data`  input  32  word to store on a write.
- `Read_Block`  output  128  refill block, registered; word at offset n occupies bits [32n+31:32n].
- `Mem_Done`  output  1  one-cycle completion pulse, registered.
- `Busy`  output  1  high whenever the state is not IDLE.

## Operation

- States: IDLE, RD, WR, DONE. Encoding is free.
- IDLE:
  - `Memory_Write_En`=1 → WR. Write has priority when both enables are high.
  - Else `Memory_Read_En`=1 → RD.
  - Else remain in IDLE.
  - On acceptance, latch `Address[11:2]` and `Write_Data`, and load the counter with `LATENCY-1`.
- RD and WR: the counter decrements each cycle. Enables, `Address` and `Write_Data` are ignored while busy.
- RD with counter==0: load `Read_Block` with the 4 words at {latched[9:2], 2'b00..2'b11}, then go to DONE.
- WR with counter==0: write the latched data to the latched word, then go to DONE.
- DONE: `Mem_Done`=1. Return to IDLE unconditionally.
  - Requests are sampled only in IDLE. A request still asserted at the DONE→IDLE edge is not seen until the next cycle.
  - The controller drops its enable within the DONE cycle, so no retrigger occurs.
- `Read_Block` holds its value until the next read completes. A write never changes `Read_Block`, even when it hits the same block.
- The array is not reset; its contents are undefined until written.
- Only one request is outstanding at a time. There is no queueing.

## Timing

- Reset values (asynchronous, while `rst`=0): state IDLE, `Mem_Done`=0, `Busy`=0, `Read_Block`=0, counter=0.
- Reset mid-operation: the pending write is dropped (no array update), the pending read is dropped (`Read_Block` cleared to 0), and no `Mem_Done` is produced.
- Let the acceptance edge be E0. The block stays in RD or WR for exactly `LATENCY` cycles. At edge E(LATENCY) the array write or `Read_Block` update commits and DONE is entered.
- `Mem_Done` is high from E(LATENCY) to E(LATENCY+1).
- `Busy` is high from E0 to E(LATENCY+1), i.e. `LATENCY`+1 cycles.
- Minimum spacing between two acceptances is `LATENCY`+2 edges.
- `LATENCY`=1 is legal: one busy cycle, then DONE.
- The counter width is 4 bits and never wraps; it is reloaded only on acceptance.

## Test plan

1. Assert `rst`=0 mid-simulation with random inputs → `Mem_Done`=0, `Busy`=0, `Read_Block`=128'h0 immediately, before any clock edge.
2. `LATENCY`=4, write 32'hDEADBEEF to 32'h0000_0104 → `Mem_Done` high for exactly one cycle, 4 edges after acceptance; `Busy` high for 5 cycles.
3. Write 1, 2, 3, 4 to 32'h100, 32'h104, 32'h108, 32'h10C, then read 32'h108 → `Read_Block`=128'h00000004_00000003_00000002_00000001 in the `Mem_Done` cycle.
4. Both enables high, `Address`=32'h200, `Write_Data`=32'h55 → a write is performed. A subsequent read of 32'h200 returns 32'h55 in bits [31:0].
5. Start a write of 32'hAAAA to 32'h300 over an earlier value of 32'h1111. Pulse `rst` low at busy cycle 2 → no `Mem_Done`. A subsequent read of 32'h300 returns 32'h1111.
6. Write 32'h77 to 32'h1000_0104, then read 32'h0000_0104 → word 1 = 32'h77, because the high address bits alias.
   - During that read, hold `Memory_Read_En` high through DONE and drop it in the cycle after → exactly one `Mem_Done` pulse.

Source files
------------

// File: rtl/main_memory_if.sv
// Request/response bundle between the data-cache controller (master) and main_memory (slave).
`default_nettype none

interface main_memory_if;
    logic         Memory_Read_En;
    logic         Memory_Write_En;
    logic [31:0]  Address;
    logic [31:0]  Write_Data;
    logic [127:0] Read_Block;
    logic         Mem_Done;
    logic         Busy;

    modport master (
        output Memory_Read_En, Memory_Write_En, Address, Write_Data,
        input  Read_Block, Mem_Done, Busy
    );

    modport slave (
        input  Memory_Read_En, Memory_Write_En, Address, Write_Data,
        output Read_Block, Mem_Done, Busy
    );
endinterface

`default_nettype wire

// File: rtl/main_memory.sv
// ============================================================================
// Module   : main_memory
// Purpose  : Fixed-latency backing store; 4-word block refills and single-word
//            write-through, each finished with a one-cycle Mem_Done pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module main_memory #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    main_memory_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    logic [1:0]   state;
    logic [3:0]   count;
    logic [9:0]   word_addr;
    logic [31:0]  wdata;
    logic [127:0] read_block;
    logic         mem_done;

    logic [31:0]  mem [DEPTH_WORDS];

    // Byte-offset and tag bits above the 10-bit word index are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.Address[31:12], bus.Address[1:0]};

    logic commit;
    assign commit = (count == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            word_addr  <= 10'd0;
            wdata      <= 32'd0;
            read_block <= 128'd0;
            mem_done   <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Memory_Write_En) begin
                        state     <= WR;
                        word_addr <= bus.Address[11:2];
                        wdata     <= bus.Write_Data;
                        count     <= LOAD_COUNT;
                    end else if (bus.Memory_Read_En) begin
                        state     <= RD;
                        word_addr <= bus.Address[11:2];
                        wdata     <= bus.Write_Data;
                        count     <= LOAD_COUNT;
                    end
                end
                RD: begin
                    if (commit) begin
                        read_block <= {mem[{word_addr[9:2], 2'd3}],
                                       mem[{word_addr[9:2], 2'd2}],
                                       mem[{word_addr[9:2], 2'd1}],
                                       mem[{word_addr[9:2], 2'd0}]};
                        state      <= DONE;
                        mem_done   <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                WR: begin
                    if (commit) begin
                        state    <= DONE;
                        mem_done <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array is deliberately unreset; a reset drops state out of WR so no write lands.
    always_ff @(posedge clk) begin
        if (state == WR && commit) begin
            mem[word_addr] <= wdata;
        end
    end

    assign bus.Read_Block = read_block;
    assign bus.Mem_Done   = mem_done;
    assign bus.Busy       = (state != IDLE);

endmodule

`default_nettype wire
